wallace_mult_pipe: RTL

//   Parametrised, pipelined Wallace-tree multiplier with valid/ready flow control.

---
 rtl/wallace_mult_pipe.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/wallace_mult_pipe.sv
`default_nettype none
// ============================================================================
// Module      : wallace_mult_pipe
// Description : Three-stage WIDTH x WIDTH Wallace-tree multiplier with
//               valid/ready flow control, per-transaction signed/unsigned
//               mode (Baugh-Wooley) and full backpressure.
//               Optional accumulate mode: define WALLACE_MULT_ACC_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module wallace_mult_pipe #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_signed,
`ifdef WALLACE_MULT_ACC_EN
    input  logic               in_acc,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_prod
);

    localparam int c_PW   = 2 * WIDTH;
    localparam int c_ROWS = WIDTH + 1;

    // Rows left after one layer of 3:2 compressors on n rows.
    function automatic int next_rows(input int n);
        return (n / 3) * 2 + (n % 3);
    endfunction

    function automatic int layer_count(input int n);
        int m;
        int cnt;
        m   = n;
        cnt = 0;
        for (int k = 0; k < 64; k++) begin
            if (m > 2) begin
                m   = next_rows(m);
                cnt = cnt + 1;
            end
        end
        return cnt;
    endfunction

    function automatic int rows_at(input int layer);
        int m;
        m = c_ROWS;
        for (int k = 0; k < 64; k++) begin
            if (k < layer) begin
                m = next_rows(m);
            end
        end
        return m;
    endfunction

    localparam int c_LAYERS = layer_count(c_ROWS);

    // ------------------------------------------------------------------
    // Flow control: a stage loads when empty or when its successor loads
    // ------------------------------------------------------------------
    logic r_v1;
    logic r_v2;
    logic r_v3;
    logic w_load1;
    logic w_load2;
    logic w_load3;

    assign w_load3   = !r_v3 || out_ready;
    assign w_load2   = !r_v2 || w_load3;
    assign w_load1   = !r_v1 || w_load2;
    assign in_ready  = w_load1;
    assign out_valid = r_v3;

    // ------------------------------------------------------------------
    // Stage 1: operand capture
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic             r_s1_sgn;
`ifdef WALLACE_MULT_ACC_EN
    logic             r_s1_acc;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1     <= 1'b0;
            r_s1_a   <= '0;
            r_s1_b   <= '0;
            r_s1_sgn <= 1'b0;
`ifdef WALLACE_MULT_ACC_EN
            r_s1_acc <= 1'b0;
`endif
        end else if (w_load1) begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_s1_a   <= in_a;
                r_s1_b   <= in_b;
                r_s1_sgn <= in_signed;
`ifdef WALLACE_MULT_ACC_EN
                r_s1_acc <= in_acc;
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: partial products and Wallace reduction to two rows
    // ------------------------------------------------------------------
    logic [c_PW-1:0] w_tree [c_ROWS];
    logic [c_PW-1:0] w_next [c_ROWS];
    logic [c_PW-1:0] w_maj;
    logic [c_PW-1:0] w_sum;
    logic [c_PW-1:0] w_carry;

    always_comb begin
        int n;
        for (int r = 0; r < c_ROWS; r++) begin
            w_tree[r] = '0;
            w_next[r] = '0;
        end
        w_maj = '0;

        // Baugh-Wooley: cross terms with exactly one sign bit are inverted.
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                w_tree[i][i+j] = (r_s1_a[j] & r_s1_b[i])
                               ^ (r_s1_sgn & ((i == WIDTH-1) != (j == WIDTH-1)));
            end
        end
        // Correction row: +2^WIDTH + 2^(2*WIDTH-1) in signed mode only.
        w_tree[WIDTH][WIDTH]  = r_s1_sgn;
        w_tree[WIDTH][c_PW-1] = r_s1_sgn;

        for (int l = 0; l < c_LAYERS; l++) begin
            n = rows_at(l);
            for (int r = 0; r < c_ROWS; r++) begin
                w_next[r] = '0;
            end
            for (int g = 0; g < c_ROWS / 3; g++) begin
                if (g < n / 3) begin
                    w_maj = (w_tree[3*g]   & w_tree[3*g+1])
                          | (w_tree[3*g]   & w_tree[3*g+2])
                          | (w_tree[3*g+1] & w_tree[3*g+2]);
                    w_next[2*g]   = w_tree[3*g] ^ w_tree[3*g+1] ^ w_tree[3*g+2];
                    w_next[2*g+1] = {w_maj[c_PW-2:0], 1'b0};
                end
            end
            // Rows that did not form a full group of three pass through.
            for (int k = 0; k < 2; k++) begin
                if (k < n % 3) begin
                    w_next[2*(n/3)+k] = w_tree[3*(n/3)+k];
                end
            end
            w_tree = w_next;
        end

        w_sum   = w_tree[0];
        w_carry = w_tree[1];
    end

    logic [c_PW-1:0] r_s2_sum;
    logic [c_PW-1:0] r_s2_carry;
`ifdef WALLACE_MULT_ACC_EN
    logic            r_s2_acc;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v2       <= 1'b0;
            r_s2_sum   <= '0;
            r_s2_carry <= '0;
`ifdef WALLACE_MULT_ACC_EN
            r_s2_acc   <= 1'b0;
`endif
        end else if (w_load2) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_s2_sum   <= w_sum;
                r_s2_carry <= w_carry;
`ifdef WALLACE_MULT_ACC_EN
                r_s2_acc   <= r_s1_acc;
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: carry-propagate add (plus optional accumulate)
    // ------------------------------------------------------------------
    logic [c_PW-1:0] r_out_prod;
    logic [c_PW-1:0] w_result;

`ifdef WALLACE_MULT_ACC_EN
    logic [c_PW-1:0] r_acc;
    logic [c_PW-1:0] w_acc_base;

    // Forward the product being handed off this cycle so chained
    // accumulations never wait for r_acc to catch up.
    assign w_acc_base = (r_v3 && out_ready) ? r_out_prod : r_acc;
    assign w_result   = r_s2_sum + r_s2_carry + (r_s2_acc ? w_acc_base : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (r_v3 && out_ready) begin
            r_acc <= r_out_prod;
        end
    end
`else
    assign w_result = r_s2_sum + r_s2_carry;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v3       <= 1'b0;
            r_out_prod <= '0;
        end else if (w_load3) begin
            r_v3 <= r_v2;
            if (r_v2) begin
                r_out_prod <= w_result;
            end
        end
    end

    assign out_prod = r_out_prod;

endmodule
`default_nettype wire
